// File: rtl/csr_write_unit.sv
// Architectural write side of the machine CSR file.
// Serialises one Zicsr read-modify-write at a time and owns the 64-bit mcycle/minstret
// counters, so software writes and hardware increments are arbitrated in one place.
module csr_write_unit #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned CSR_ADDR_WIDTH = 12
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic [CSR_ADDR_WIDTH-1:0] req_addr_i,
  input  logic [2:0]                req_funct3_i,
  input  logic [DATA_WIDTH-1:0]     req_rs1_data_i,
  input  logic [4:0]                req_rs1_idx_i,
  input  logic                      retire_i,
  output logic                      resp_valid_o,
  output logic [DATA_WIDTH-1:0]     resp_rdata_o,
  output logic                      resp_illegal_o
);

  localparam int unsigned CntWidth = 2 * DATA_WIDTH;

  localparam logic [CSR_ADDR_WIDTH-1:0] AddrMscratch = CSR_ADDR_WIDTH'(32'h340);
  localparam logic [CSR_ADDR_WIDTH-1:0] AddrMcycle   = CSR_ADDR_WIDTH'(32'hB00);
  localparam logic [CSR_ADDR_WIDTH-1:0] AddrMcycleH  = CSR_ADDR_WIDTH'(32'hB80);
  localparam logic [CSR_ADDR_WIDTH-1:0] AddrMinstr   = CSR_ADDR_WIDTH'(32'hB02);
  localparam logic [CSR_ADDR_WIDTH-1:0] AddrMinstrH  = CSR_ADDR_WIDTH'(32'hB82);
  localparam logic [CSR_ADDR_WIDTH-1:0] AddrCycle    = CSR_ADDR_WIDTH'(32'hC00);
  localparam logic [CSR_ADDR_WIDTH-1:0] AddrCycleH   = CSR_ADDR_WIDTH'(32'hC80);
  localparam logic [CSR_ADDR_WIDTH-1:0] AddrInstr    = CSR_ADDR_WIDTH'(32'hC02);
  localparam logic [CSR_ADDR_WIDTH-1:0] AddrInstrH   = CSR_ADDR_WIDTH'(32'hC82);

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StResp} state_e;

  state_e                    state_q, state_d;
  logic [CSR_ADDR_WIDTH-1:0] addr_q;
  logic [2:0]                funct3_q;
  logic [DATA_WIDTH-1:0]     rs1_data_q;
  logic [4:0]                rs1_idx_q;
  logic [DATA_WIDTH-1:0]     old_q;
  logic                      illegal_q;
  logic                      commit_q;
  logic [DATA_WIDTH-1:0]     mscratch_q, mscratch_d;
  logic [CntWidth-1:0]       mcycle_q, mcycle_d;
  logic [CntWidth-1:0]       minstret_q, minstret_d;

  logic                  sel_mscratch, sel_mcyc_lo, sel_mcyc_hi, sel_mins_lo, sel_mins_hi;
  logic                  sel_ro, mapped, wr_attempt, illegal;
  logic [DATA_WIDTH-1:0] csr_rdata, src, new_val;

  // Address decode of the captured request; read-only mirrors alias the same counter halves.
  assign sel_mscratch = (addr_q == AddrMscratch);
  assign sel_mcyc_lo  = (addr_q == AddrMcycle) || (addr_q == AddrCycle);
  assign sel_mcyc_hi  = (addr_q == AddrMcycleH) || (addr_q == AddrCycleH);
  assign sel_mins_lo  = (addr_q == AddrMinstr) || (addr_q == AddrInstr);
  assign sel_mins_hi  = (addr_q == AddrMinstrH) || (addr_q == AddrInstrH);
  assign sel_ro       = (addr_q == AddrCycle) || (addr_q == AddrCycleH) ||
                        (addr_q == AddrInstr) || (addr_q == AddrInstrH);
  assign mapped       = sel_mscratch | sel_mcyc_lo | sel_mcyc_hi | sel_mins_lo | sel_mins_hi;

  // Set/clear forms with rs1=x0 are pure reads; RW forms always write.
  assign wr_attempt = (funct3_q[1:0] == 2'b01) || (rs1_idx_q != 5'd0);
  assign illegal    = (funct3_q[1:0] == 2'b00) || !mapped || (wr_attempt && sel_ro);

  // Current value of the addressed CSR.
  always_comb begin
    csr_rdata = '0;
    if (sel_mscratch)     csr_rdata = mscratch_q;
    else if (sel_mcyc_lo) csr_rdata = mcycle_q[DATA_WIDTH-1:0];
    else if (sel_mcyc_hi) csr_rdata = mcycle_q[CntWidth-1:DATA_WIDTH];
    else if (sel_mins_lo) csr_rdata = minstret_q[DATA_WIDTH-1:0];
    else if (sel_mins_hi) csr_rdata = minstret_q[CntWidth-1:DATA_WIDTH];
  end

  // Operand select and read-modify-write value, built from the value latched in READ.
  always_comb begin
    src     = req_funct3_zimm(funct3_q) ? DATA_WIDTH'(rs1_idx_q) : rs1_data_q;
    new_val = src;
    unique case (funct3_q[1:0])
      2'b10:   new_val = old_q | src;
      2'b11:   new_val = old_q & ~src;
      default: new_val = src;
    endcase
  end

  function automatic logic req_funct3_zimm(input logic [2:0] f3);
    return f3[2];
  endfunction

  // Counters free-run; a committed write to a half freezes that counter for the cycle.
  always_comb begin
    mscratch_d = mscratch_q;
    mcycle_d   = mcycle_q + CntWidth'(1);
    minstret_d = minstret_q + CntWidth'(retire_i);
    if ((state_q == StWrite) && commit_q) begin
      if (sel_mscratch) mscratch_d = new_val;
      if (sel_mcyc_lo)  mcycle_d   = {mcycle_q[CntWidth-1:DATA_WIDTH], new_val};
      if (sel_mcyc_hi)  mcycle_d   = {new_val, mcycle_q[DATA_WIDTH-1:0]};
      if (sel_mins_lo)  minstret_d = {minstret_q[CntWidth-1:DATA_WIDTH], new_val};
      if (sel_mins_hi)  minstret_d = {new_val, minstret_q[DATA_WIDTH-1:0]};
    end
  end

  // Next-state: fixed four-cycle walk once a request is accepted.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (req_valid_i) state_d = StRead;
      StRead:  state_d = StWrite;
      StWrite: state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State, architectural CSRs and captured transaction registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      funct3_q   <= '0;
      rs1_data_q <= '0;
      rs1_idx_q  <= '0;
      old_q      <= '0;
      illegal_q  <= 1'b0;
      commit_q   <= 1'b0;
      mscratch_q <= '0;
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      state_q    <= state_d;
      mscratch_q <= mscratch_d;
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
      if ((state_q == StIdle) && req_valid_i) begin
        addr_q     <= req_addr_i;
        funct3_q   <= req_funct3_i;
        rs1_data_q <= req_rs1_data_i;
        rs1_idx_q  <= req_rs1_idx_i;
      end
      if (state_q == StRead) begin
        old_q     <= csr_rdata;
        illegal_q <= illegal;
        commit_q  <= wr_attempt && !illegal;
      end
    end
  end

  // Handshake and response outputs; data is forced to zero for illegal accesses.
  always_comb begin
    req_ready_o    = (state_q == StIdle);
    resp_valid_o   = (state_q == StResp);
    resp_illegal_o = (state_q == StResp) && illegal_q;
    resp_rdata_o   = ((state_q == StResp) && !illegal_q) ? old_q : '0;
  end

endmodule

// File: tb/tb_csr_write_unit.sv
// Self-checking bench for csr_write_unit: randomised Zicsr traffic against a timestamped
// CSR model, with a scoreboard queue drained by an independent response monitor.
module tb_csr_write_unit;

  localparam int MaxEdges = 40000;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [11:0] req_addr;
  logic [2:0]  req_funct3;
  logic [31:0] req_rs1_data;
  logic [4:0]  req_rs1_idx;
  logic        retire;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_illegal;

  int n_cmp  = 0;
  int n_fail = 0;
  int ecnt   = 0;
  int cum [0:MaxEdges];
  bit retire_en = 1'b0;

  typedef struct {
    logic [31:0] rdata;
    logic        ill;
    int          resp_e;
  } exp_t;
  exp_t exp_q[$];

  // Model: counters as (value, edge-of-value) pairs, advanced arithmetically on demand.
  logic [31:0] m_mscratch;
  logic [63:0] m_mc_base, m_mi_base;
  int          m_mc_e, m_mi_e;

  csr_write_unit #(.DATA_WIDTH(32), .CSR_ADDR_WIDTH(12)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid_i   (req_valid),
    .req_ready_o   (req_ready),
    .req_addr_i    (req_addr),
    .req_funct3_i  (req_funct3),
    .req_rs1_data_i(req_rs1_data),
    .req_rs1_idx_i (req_rs1_idx),
    .retire_i      (retire),
    .resp_valid_o  (resp_valid),
    .resp_rdata_o  (resp_rdata),
    .resp_illegal_o(resp_illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] mc_at(input int e);
    return m_mc_base + 64'(e - m_mc_e);
  endfunction

  function automatic logic [63:0] mi_at(input int e);
    return m_mi_base + 64'(cum[e] - cum[m_mi_e]);
  endfunction

  task automatic model_reset();
    m_mscratch = 32'h0;
    m_mc_base  = 64'h0;
    m_mi_base  = 64'h0;
    m_mc_e     = ecnt;
    m_mi_e     = ecnt;
  endtask

  // Edge counter with cumulative retire count sampled at each rising edge.
  initial forever begin
    @(posedge clk);
    if (ecnt < MaxEdges) cum[ecnt+1] = cum[ecnt] + (retire ? 1 : 0);
    ecnt++;
  end

  // Random retire pulses.
  initial forever begin
    @(negedge clk);
    retire = retire_en ? 1'($urandom_range(0, 1)) : 1'b0;
  end

  // Response monitor: pops the scoreboard whenever the DUT responds or a response is overdue.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (resp_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_resp: got resp_valid=1 rdata=0x%0h, expected no response",
                   resp_rdata);
        end else begin
          e = exp_q.pop_front();
          chk("resp_rdata", 64'(resp_rdata), 64'(e.rdata));
          chk("resp_illegal", 64'(resp_illegal), 64'(e.ill));
          chk("resp_latency_edge", 64'(ecnt), 64'(e.resp_e));
        end
      end else if (exp_q.size() > 0 && ecnt > exp_q[0].resp_e) begin
        e = exp_q.pop_front();
        n_cmp++;
        n_fail++;
        $display("FAIL missing_resp: got no resp_valid by edge %0d, expected one at edge %0d",
                 ecnt, e.resp_e);
      end
    end
  end

  task automatic wait_ready(output bit ok);
    int waited = 0;
    @(negedge clk);
    while (req_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    ok = (req_ready === 1'b1);
    if (!ok) begin
      n_cmp++;
      n_fail++;
      $display("FAIL ready_timeout: got req_ready=%b after 20 cycles, expected 1", req_ready);
    end
  endtask

  // Issue one instruction, then derive its expected response and CSR effects.
  task automatic do_op(input logic [11:0] addr, input logic [2:0] f3, input logic [31:0] data,
                       input logic [4:0] idx);
    bit          ok, ro, writes, illegal;
    int          a, tgt;
    logic [63:0] cyc_old, ins_old, cur;
    logic [31:0] oldv, src, newv;
    exp_t        ex;
    wait_ready(ok);
    if (!ok) return;
    req_valid    = 1'b1;
    req_addr     = addr;
    req_funct3   = f3;
    req_rs1_data = data;
    req_rs1_idx  = idx;
    @(posedge clk);
    #1;
    a = ecnt;
    // Sometimes leave a bogus request asserted while busy; it must be ignored.
    if ($urandom_range(0, 1) == 1) begin
      req_addr     = 12'h340;
      req_funct3   = 3'b001;
      req_rs1_data = $urandom;
      req_rs1_idx  = 5'd1;
    end else begin
      req_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;

    ro = 1'b0;
    case (addr)
      12'h340: tgt = 0;
      12'hB00: tgt = 1;
      12'hB80: tgt = 2;
      12'hB02: tgt = 3;
      12'hB82: tgt = 4;
      12'hC00: begin tgt = 1; ro = 1'b1; end
      12'hC80: begin tgt = 2; ro = 1'b1; end
      12'hC02: begin tgt = 3; ro = 1'b1; end
      12'hC82: begin tgt = 4; ro = 1'b1; end
      default: tgt = -1;
    endcase
    writes  = (f3[1:0] == 2'b01) || (idx != 5'd0);
    illegal = (f3[1:0] == 2'b00) || (tgt < 0) || (writes && ro);
    cyc_old = mc_at(a);
    ins_old = mi_at(a);
    case (tgt)
      0:       oldv = m_mscratch;
      1:       oldv = cyc_old[31:0];
      2:       oldv = cyc_old[63:32];
      3:       oldv = ins_old[31:0];
      4:       oldv = ins_old[63:32];
      default: oldv = 32'h0;
    endcase
    ex.rdata  = illegal ? 32'h0 : oldv;
    ex.ill    = illegal;
    ex.resp_e = a + 2;
    exp_q.push_back(ex);

    if (!illegal && writes) begin
      src = f3[2] ? {27'h0, idx} : data;
      case (f3[1:0])
        2'b10:   newv = oldv | src;
        2'b11:   newv = oldv & ~src;
        default: newv = src;
      endcase
      case (tgt)
        0: m_mscratch = newv;
        1: begin cur = mc_at(a + 1); m_mc_base = {cur[63:32], newv}; m_mc_e = a + 2; end
        2: begin cur = mc_at(a + 1); m_mc_base = {newv, cur[31:0]};  m_mc_e = a + 2; end
        3: begin cur = mi_at(a + 1); m_mi_base = {cur[63:32], newv}; m_mi_e = a + 2; end
        4: begin cur = mi_at(a + 1); m_mi_base = {newv, cur[31:0]};  m_mi_e = a + 2; end
        default: ;
      endcase
    end
  endtask

  logic [11:0] addr_tab [0:12];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got no completion within time limit, expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    bit ok;
    rst          = 1'b1;
    req_valid    = 1'b0;
    req_addr     = 12'h0;
    req_funct3   = 3'b0;
    req_rs1_data = 32'h0;
    req_rs1_idx  = 5'd0;
    retire       = 1'b0;
    addr_tab = '{12'h340, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'hC80, 12'hC02,
                 12'hC82, 12'h341, 12'h123, 12'hB01, 12'hC01};

    repeat (3) @(negedge clk);
    chk("reset_req_ready", 64'(req_ready), 64'h1);
    chk("reset_resp_valid", 64'(resp_valid), 64'h0);
    chk("reset_resp_rdata", 64'(resp_rdata), 64'h0);
    chk("reset_resp_illegal", 64'(resp_illegal), 64'h0);
    rst = 1'b0;
    model_reset();
    retire_en = 1'b1;

    // mscratch RW then read-back via RS x0.
    do_op(12'h340, 3'b001, 32'hDEADBEEF, 5'd5);
    do_op(12'h340, 3'b010, 32'hFFFFFFFF, 5'd0);
    // Immediate set/clear.
    do_op(12'h340, 3'b001, 32'h000000F0, 5'd1);
    do_op(12'h340, 3'b110, 32'hFFFFFFFF, 5'd5);
    do_op(12'h340, 3'b111, 32'h0, 5'h10);
    do_op(12'h340, 3'b010, 32'h0, 5'd0);
    // mcycle carry out of a freshly written low half.
    do_op(12'hB80, 3'b001, 32'h0, 5'd1);
    do_op(12'hB00, 3'b001, 32'hFFFFFFFF, 5'd1);
    do_op(12'hB00, 3'b010, 32'h0, 5'd0);
    do_op(12'hB80, 3'b010, 32'h0, 5'd0);
    // Full 64-bit wrap of mcycle.
    do_op(12'hB80, 3'b001, 32'hFFFFFFFF, 5'd1);
    do_op(12'hB00, 3'b001, 32'hFFFFFFFE, 5'd1);
    do_op(12'hC80, 3'b010, 32'h0, 5'd0);
    do_op(12'hC00, 3'b011, 32'h0, 5'd0);
    // minstret write racing retire pulses.
    do_op(12'hB02, 3'b001, 32'h100, 5'd2);
    do_op(12'hB02, 3'b010, 32'h0, 5'd0);
    do_op(12'hC82, 3'b010, 32'h0, 5'd0);
    // Illegal forms.
    do_op(12'hC00, 3'b001, 32'h55, 5'd1);
    do_op(12'hC02, 3'b010, 32'h0, 5'd0);
    do_op(12'hC02, 3'b110, 32'h0, 5'd3);
    do_op(12'h340, 3'b000, 32'h77, 5'd1);
    do_op(12'h340, 3'b100, 32'h77, 5'd1);
    do_op(12'h341, 3'b001, 32'h77, 5'd1);
    do_op(12'h340, 3'b010, 32'h0, 5'd0);

    // Reset during the WRITE cycle of a CSRRW to mscratch.
    wait_ready(ok);
    if (ok) begin
      req_valid    = 1'b1;
      req_addr     = 12'h340;
      req_funct3   = 3'b001;
      req_rs1_data = 32'h1234;
      req_rs1_idx  = 5'd3;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_resp_valid", 64'(resp_valid), 64'h0);
      chk("midrst_req_ready", 64'(req_ready), 64'h1);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      model_reset();
      @(negedge clk);
      chk("post_rst_req_ready", 64'(req_ready), 64'h1);
    end
    do_op(12'h340, 3'b010, 32'h0, 5'd0);
    do_op(12'hB00, 3'b010, 32'h0, 5'd0);

    // Randomised traffic.
    for (int i = 0; i < 250; i++) begin
      logic [4:0] idx;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      idx = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      do_op(addr_tab[$urandom_range(0, 12)], 3'($urandom), $urandom, idx);
    end

    repeat (6) @(negedge clk);
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_cmp++;
      n_fail++;
      $display("FAIL leftover_expect: got no response, expected rdata 0x%0h", e.rdata);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
